s6bit_alu_seq: RTL and testbench
================================

S6BIT_ALU_SEQ -- requirements
Module: s6bit_alu_seq

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-003 SHALL have port in_valid, input, 1, operand/opcode presented.
REQ-004 SHALL have port in_ready, output, 1, block accepts a new operation.
REQ-005 SHALL have port op, input, 2, opcode: 00 add, 01 sub, 10 mul, 11 reserved.
REQ-006 SHALL have port x, input, 6, signed two's-complement operand A.
REQ-007 SHALL have port y, input, 6, signed two's-complement operand B.
REQ-008 SHALL have port out_valid, output, 1, result available.
REQ-009 SHALL have port out_ready, input, 1, downstream consumes result.
REQ-010 SHALL have port result, output, 12, signed result.
REQ-011 SHALL have port overflow, output, 1, signed overflow of add/sub.
REQ-012 SHALL have port busy, output, 1, high in any state except IDLE.

Function
REQ-013 SHALL implement FSM states IDLE, MUL, DONE.
REQ-014 in_ready SHALL be 1 only in IDLE; accept = in_valid & in_ready on a rising edge; x, y, op captured at accept.
REQ-015 IDLE, accept, op 00/01/11: SHALL load result/overflow and go to DONE (out_valid 1 cycle after accept).
REQ-016 IDLE, accept, op 10: SHALL go to MUL with step counter 0.
REQ-017 MUL SHALL perform one radix-2 Booth step per cycle, 6 steps (counter 0..5), then go to DONE (out_valid 7 cycles after accept).
REQ-018 DONE SHALL hold out_valid=1 with result/overflow stable until out_ready=1 on an edge, then go to IDLE.
REQ-019 out_valid and in_ready SHALL never both be 1 (no DONE->accept bypass; next accept earliest 1 cycle after handoff).
REQ-020 Add/sub SHALL compute 6-bit wrap-around x+y / x-y, sign-extended to 12 bits.
REQ-021 Add overflow SHALL be 1 when x,y same sign and sum sign differs; sub overflow when x,y signs differ and diff sign differs from x.
REQ-022 Mul SHALL produce exact 12-bit signed x*y; overflow SHALL be 0.
REQ-023 Reserved op 11 SHALL yield result 0, overflow 0.
REQ-024 in_valid/x/y/op changes while busy SHALL have no effect.
REQ-025 out_ready while not in DONE SHALL be ignored.

Reset
REQ-026 rst=1 SHALL immediately force state IDLE, result 0, overflow 0, out_valid 0, busy 0, step counter 0, Booth registers 0.
REQ-027 in_ready SHALL be 0 while rst=1 and 1 from the first cycle after rst deasserts.
REQ-028 Reset mid-MUL or in DONE SHALL discard the operation; no out_valid is produced for it.

Configuration
REQ-029 Macro S6BIT_ALU_SAT_EN SHALL, when defined, saturate add/sub on overflow: positive overflow -> +31 (12'h01F), negative -> -32 (12'hFE0); overflow still 1.
REQ-030 Without S6BIT_ALU_SAT_EN, add/sub SHALL wrap per REQ-020; mul and reserved op SHALL be identical in both builds.

Verification
REQ-031 add x=3, y=4 -> out_valid 1 cycle after accept, result 12'h007, overflow 0.
REQ-032 add x=31, y=1 -> result 12'hFE0, overflow 1; with S6BIT_ALU_SAT_EN result 12'h01F, overflow 1.
REQ-033 sub x=-32, y=1 -> result 12'h01F, overflow 1; with S6BIT_ALU_SAT_EN result 12'hFE0.
REQ-034 mul x=-32, y=-32 -> out_valid 7 cycles after accept, result 12'h400; mul x=-3, y=5 -> 12'hFF1; busy 1 throughout.
REQ-035 out_ready held 0 for 5 cycles in DONE with in_valid=1 -> result stable, in_ready 0, no new accept; out_ready 1 -> IDLE next cycle.
REQ-036 rst pulsed during MUL step 3 -> out_valid 0, result 0, in_ready 1 after release; the next operation completes correctly.

Source files
------------

// File: rtl/s6bit_alu_seq.sv
// Sequential 6-bit signed ALU: one-cycle add/sub, 6-step radix-2 Booth mul.
// Define S6BIT_ALU_SAT_EN to saturate add/sub results on signed overflow.
module s6bit_alu_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  op,
  input  logic [5:0]  x,
  input  logic [5:0]  y,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [11:0] result,
  output logic        overflow,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DONE
  } state_t;

  state_t      state_q, state_d;
  logic [11:0] result_q, result_d;
  logic        ovf_q, ovf_d;
  logic        out_valid_q, out_valid_d;
  logic        busy_q, busy_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [6:0]  a_q, a_d;
  logic [5:0]  m_q, m_d;
  logic [5:0]  b_q, b_d;
  logic        q1_q, q1_d;

  logic        accept;
  logic [5:0]  sum;
  logic [5:0]  dif;
  logic [11:0] as_res;
  logic        as_ovf;
  logic [6:0]  m_ext;
  logic [6:0]  a_sum;
  logic [12:0] shifted;

  assign in_ready  = (state_q == IDLE) & ~rst;
  assign accept    = in_valid & in_ready;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign result    = result_q;
  assign overflow  = ovf_q;

  assign sum = x + y;
  assign dif = x - y;

  always_comb begin
    as_res = 12'h000;
    as_ovf = 1'b0;
    unique case (op)
      2'b00: begin
        as_res = {{6{sum[5]}}, sum};
        as_ovf = (x[5] == y[5]) && (sum[5] != x[5]);
      end
      2'b01: begin
        as_res = {{6{dif[5]}}, dif};
        as_ovf = (x[5] != y[5]) && (dif[5] != x[5]);
      end
      default: begin
        as_res = 12'h000;
        as_ovf = 1'b0;
      end
    endcase
`ifdef S6BIT_ALU_SAT_EN
    // Overflow direction always follows the sign of x for add and sub.
    if (as_ovf) begin
      as_res = x[5] ? 12'hFE0 : 12'h01F;
    end
`endif
  end

  // A is 7 bits wide so subtracting M = -32 cannot wrap.
  assign m_ext = {m_q[5], m_q};

  always_comb begin
    a_sum = a_q;
    unique case ({b_q[0], q1_q})
      2'b01:   a_sum = a_q + m_ext;
      2'b10:   a_sum = a_q - m_ext;
      default: a_sum = a_q;
    endcase
  end

  assign shifted = {a_sum[6], a_sum, b_q[5:1]};

  always_comb begin
    state_d     = state_q;
    result_d    = result_q;
    ovf_d       = ovf_q;
    cnt_d       = cnt_q;
    a_d         = a_q;
    m_d         = m_q;
    b_d         = b_q;
    q1_d        = q1_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (op == 2'b10) begin
            state_d = MUL;
            cnt_d   = 3'd0;
            a_d     = 7'd0;
            m_d     = x;
            b_d     = y;
            q1_d    = 1'b0;
          end else begin
            state_d  = DONE;
            result_d = as_res;
            ovf_d    = as_ovf;
          end
        end
      end
      MUL: begin
        a_d  = shifted[12:6];
        b_d  = shifted[5:0];
        q1_d = b_q[0];
        if (cnt_q == 3'd5) begin
          state_d  = DONE;
          result_d = {shifted[11:6], shifted[5:0]};
          ovf_d    = 1'b0;
          cnt_d    = 3'd0;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    out_valid_d = (state_d == DONE);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      result_q    <= 12'h000;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      cnt_q       <= 3'd0;
      a_q         <= 7'd0;
      m_q         <= 6'd0;
      b_q         <= 6'd0;
      q1_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      result_q    <= result_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      cnt_q       <= cnt_d;
      a_q         <= a_d;
      m_q         <= m_d;
      b_q         <= b_d;
      q1_q        <= q1_d;
    end
  end

endmodule

// File: tb/tb_s6bit_alu_seq.sv
// Directed bench for s6bit_alu_seq: add/sub/mul/reserved, handshake, reset.
module tb_s6bit_alu_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  op;
  logic [5:0]  x;
  logic [5:0]  y;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] result;
  logic        overflow;
  logic        busy;

  int checks = 0;
  int failures = 0;

  s6bit_alu_seq dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .x(x), .y(y), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .overflow(overflow), .busy(busy)
  );

  always #5 clk = ~clk;

  // Launches one op, waits for out_valid, returns what was seen, hands off.
  task automatic run_op(input logic [1:0] o, input logic [5:0] a,
                        input logic [5:0] b, input bit noise,
                        output int lat, output logic [11:0] res,
                        output logic ovf, output bit busy_all);
    @(negedge clk);
    in_valid = 1'b1; op = o; x = a; y = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    busy_all = busy;
    while (!out_valid && lat < 20) begin
      if (noise) begin
        in_valid = 1'b1; op = 2'b00;
        x = 6'($urandom); y = 6'($urandom);
      end
      @(posedge clk); #1;
      lat++;
      busy_all = busy_all & busy;
    end
    in_valid = 1'b0;
    res = result;
    ovf = overflow;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    op = 2'b00; x = 6'd0; y = 6'd0;
    #12;
    checks++;
    if ({in_ready, out_valid, busy, overflow, result} !== 16'h0000) begin
      failures++;
      $display("FAIL reset_state rdy=%b ov=%b busy=%b ovf=%b res=%h want 0",
               in_ready, out_valid, busy, overflow, result);
    end
    @(negedge clk); rst = 1'b0; #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_release in_ready=%b want 1", in_ready);
    end
  endtask

  task automatic test_addsub();
    logic [1:0]  vo [7];
    logic [5:0]  va [7];
    logic [5:0]  vb [7];
    logic [11:0] vr [7];
    logic        vf [7];
    int lat; logic [11:0] res; logic ovf; bit ba;
    vo[0]=2'b00; va[0]=6'd3;  vb[0]=6'd4;  vr[0]=12'h007; vf[0]=0;
    vo[1]=2'b00; va[1]=6'd31; vb[1]=6'd1;  vf[1]=1;
    vo[2]=2'b00; va[2]=6'h20; vb[2]=6'h3F; vf[2]=1;
    vo[3]=2'b00; va[3]=6'h3B; vb[3]=6'd3;  vr[3]=12'hFFE; vf[3]=0;
    vo[4]=2'b01; va[4]=6'h20; vb[4]=6'd1;  vf[4]=1;
    vo[5]=2'b01; va[5]=6'd5;  vb[5]=6'd7;  vr[5]=12'hFFE; vf[5]=0;
    vo[6]=2'b01; va[6]=6'd31; vb[6]=6'h3F; vf[6]=1;
`ifdef S6BIT_ALU_SAT_EN
    vr[1]=12'h01F; vr[2]=12'hFE0; vr[4]=12'hFE0; vr[6]=12'h01F;
`else
    vr[1]=12'hFE0; vr[2]=12'h01F; vr[4]=12'h01F; vr[6]=12'hFE0;
`endif
    for (int i = 0; i < 7; i++) begin
      run_op(vo[i], va[i], vb[i], 1'b0, lat, res, ovf, ba);
      checks++;
      if (lat !== 1 || res !== vr[i] || ovf !== vf[i]) begin
        failures++;
        $display("FAIL addsub[%0d] lat=%0d res=%h ovf=%b want lat=1 res=%h ovf=%b",
                 i, lat, res, ovf, vr[i], vf[i]);
      end
    end
  endtask

  task automatic test_reserved();
    int lat; logic [11:0] res; logic ovf; bit ba;
    run_op(2'b11, 6'd9, 6'd9, 1'b0, lat, res, ovf, ba);
    checks++;
    if (lat !== 1 || res !== 12'h000 || ovf !== 1'b0) begin
      failures++;
      $display("FAIL reserved lat=%0d res=%h ovf=%b want lat=1 res=000 ovf=0",
               lat, res, ovf);
    end
  endtask

  task automatic test_mul();
    logic [5:0]  va [5];
    logic [5:0]  vb [5];
    logic [11:0] vr [5];
    int lat; logic [11:0] res; logic ovf; bit ba;
    va[0]=6'h20; vb[0]=6'h20; vr[0]=12'h400;
    va[1]=6'h3D; vb[1]=6'd5;  vr[1]=12'hFF1;
    va[2]=6'd7;  vb[2]=6'h38; vr[2]=12'hFC8;
    va[3]=6'd31; vb[3]=6'd31; vr[3]=12'h3C1;
    va[4]=6'd0;  vb[4]=6'h3B; vr[4]=12'h000;
    for (int i = 0; i < 5; i++) begin
      run_op(2'b10, va[i], vb[i], i == 1, lat, res, ovf, ba);
      checks++;
      if (lat !== 7 || res !== vr[i] || ovf !== 1'b0 || !ba) begin
        failures++;
        $display("FAIL mul[%0d] lat=%0d res=%h ovf=%b busy=%b want 7 %h 0 1",
                 i, lat, res, ovf, ba, vr[i]);
      end
    end
  endtask

  task automatic test_hold();
    bit bad = 0;
    @(negedge clk);
    in_valid = 1'b1; op = 2'b00; x = 6'd5; y = 6'h3E;
    @(posedge clk); #1;
    x = 6'd9; y = 6'd9;
    for (int i = 0; i < 5; i++) begin
      if (out_valid !== 1'b1 || in_ready !== 1'b0 ||
          result !== 12'h003 || overflow !== 1'b0) bad = 1;
      @(posedge clk); #1;
    end
    checks++;
    if (bad || out_valid !== 1'b1 || result !== 12'h003) begin
      failures++;
      $display("FAIL hold ov=%b rdy=%b res=%h want ov=1 rdy=0 res=003",
               out_valid, in_ready, result);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL hold_release rdy=%b ov=%b busy=%b want 1 0 0",
               in_ready, out_valid, busy);
    end
  endtask

  task automatic test_reset_mid_mul();
    bit seen = 0;
    int lat; logic [11:0] res; logic ovf; bit ba;
    @(negedge clk);
    in_valid = 1'b1; op = 2'b10; x = 6'd7; y = 6'd7;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({out_valid, busy, in_ready, result} !== 15'h0000) begin
      failures++;
      $display("FAIL rst_mid ov=%b busy=%b rdy=%b res=%h want all 0",
               out_valid, busy, in_ready, result);
    end
    @(negedge clk); rst = 1'b0; #1;
    for (int i = 0; i < 8; i++) begin
      if (out_valid) seen = 1;
      @(posedge clk); #1;
    end
    checks++;
    if (seen || in_ready !== 1'b1 || result !== 12'h000) begin
      failures++;
      $display("FAIL rst_mid_after ov_seen=%b rdy=%b res=%h want 0 1 000",
               seen, in_ready, result);
    end
    run_op(2'b10, 6'h3D, 6'd5, 1'b0, lat, res, ovf, ba);
    checks++;
    if (lat !== 7 || res !== 12'hFF1) begin
      failures++;
      $display("FAIL rst_mid_next lat=%0d res=%h want 7 FF1", lat, res);
    end
  endtask

  task automatic test_back_to_back();
    bit both = 0;
    int lat;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b1; op = 2'b00; x = 6'(i); y = 6'd1;
      out_ready = 1'b1;
      @(posedge clk); #1;
      if (out_valid && in_ready) both = 1;
      lat = 1;
      while (!out_valid && lat < 20) begin
        @(posedge clk); #1; lat++;
      end
      checks++;
      if (lat !== 1 || result !== 12'(i + 1) || in_ready !== 1'b0) begin
        failures++;
        $display("FAIL b2b[%0d] lat=%0d res=%h rdy=%b want 1 %h 0",
                 i, lat, result, in_ready, 12'(i + 1));
      end
      in_valid = 1'b0;
      @(posedge clk); #1;
      if (out_valid && in_ready) both = 1;
    end
    out_ready = 1'b0;
    checks++;
    if (both || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL b2b_excl both=%b rdy=%b want 0 1", both, in_ready);
    end
  endtask

  initial begin
    test_reset();
    test_addsub();
    test_reserved();
    test_mul();
    test_hold();
    test_reset_mid_mul();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout simulation exceeded 50000 time units");
    $fatal(1);
  end

endmodule
